seq_detector_model: RTL and testbench
=====================================

# seq_detector_model

Serial bit-stream pattern detector. Samples one bit of `din` per clock, compares the most recent `PAT_W` samples against a fixed pattern, and raises a registered one-cycle `dout` flag on each match. It sits on a serial data path as a frame-marker/sync-word detector; default pattern `1010`.

## Interface
- `PAT_W`, default 4: pattern length in bits; legal range 2..32.
- `PATTERN`, default 4'b1010: target sequence, `PAT_W` bits; MSB is the oldest (first-received) bit.
- `clk` input 1: single clock; all state updates on the rising edge.
- `resetn` input 1: reset, asynchronous and active-high (1 = reset asserted), despite the legacy name.
- `din` input 1: serial data bit, sampled every rising edge while reset is deasserted.
- `dout` output 1: registered match flag.

## Operation
- State:
  - history shift register, `PAT_W-1` bits, holding the previous samples;
  - fill counter, saturating at `PAT_W`, counting valid samples since reset or last clear;
  - `dout` register.
- Each edge out of reset:
  - window = {history, din};
  - `match` = (window == PATTERN) and (fill counter + 1 >= PAT_W);
  - `dout` <= `match`;
  - history shifts left by one, with `din` entering the LSB;
  - fill counter increments, saturating at `PAT_W`.
- Matches may overlap by default (see Configuration). A new match can fire on any cycle, including the cycle immediately after a previous match.
- `dout` is high for exactly one cycle per match. Back-to-back matches give `dout` high on consecutive cycles with no gap.
- No bit is ever dropped or stalled; the block is always ready.

## Timing
- Reset state: `dout` = 0, history = 0, fill counter = 0.
- Reset takes effect immediately on assertion (asynchronous), with no clock required. Deassertion is synchronised by the caller.
- Latency: the final pattern bit is sampled at edge N; `dout` is 1 from just after edge N until edge N+1.
- After reset, at least `PAT_W` samples are required before any match. A zero-valued history never aliases into a match, even when PATTERN has leading zeros.
- Reset asserted mid-stream: `dout` drops to 0 at once and all partial history is discarded. The first `PAT_W-1` samples after release cannot produce a match.
- No FSM states beyond the fill counter. The counter width is $clog2(PAT_W+1).

## Configuration
- `SEQ_DET_NONOVERLAP_EN` undefined (default): overlapping detection, as described in Operation.
- `SEQ_DET_NONOVERLAP_EN` defined: on a match cycle, the fill counter and history clear to 0 instead of shifting. The next match then requires `PAT_W` fresh samples after the matching bit; no bit is shared between two reported matches.
- In both modes, `dout` timing and the reset behaviour are identical.

## Structure
- Package `seq_det_pkg`:
  - default `PAT_W`;
  - default `PATTERN` constant;
  - localparam helper for the fill-counter width;
  - `typedef logic [PAT_W-1:0] pattern_t` for the default width.
- Sub-module `seq_det_history`: shift register plus saturating fill counter. It has a clear input driven by match when `SEQ_DET_NONOVERLAP_EN` is defined, and outputs the window and a `full` flag.
- Top `seq_detector_model` holds the comparator and the `dout` register.

## Test plan
Use the 32-bit stream `1010_1111_0101_0101_1010_1111_0000_0000`, MSB first, one bit per cycle starting after reset release. Bit indices below count from 0.

1. Reset: hold `resetn`=1 for 2 cycles with `din` toggling -> `dout`=0 throughout; after release, no match before the 4th sample.
2. Default mode, stream above -> `dout` pulses one cycle after bit indices 3, 10, 12, 14 and 19 (5 pulses), with `dout`=0 elsewhere including the trailing zeros.
3. `SEQ_DET_NONOVERLAP_EN` defined, same stream -> pulses after bits 3, 10, 14 and 19 only (4 pulses); the index-12 overlap is suppressed.
4. Mid-stream reset: feed `101`, assert `resetn` for 1 cycle, then feed `0` -> no pulse. Then feeding `1010` -> pulse after its final 0.
5. Alternate `PATTERN` (PAT_W=4, PATTERN=4'b0000): all-zero input from reset -> first pulse after the 4th zero, then every cycle in overlap mode; every 4th cycle in non-overlap mode.
6. Back-to-back: input `1010101010` in default mode -> `dout` high on alternating cycles after indices 3, 5, 7 and 9, never two consecutive ones for this pattern.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared defaults for the serial pattern detector: pattern width, default sync word, counter sizing.
package seq_det_pkg;

  localparam int PAT_W_DEF = 4;

  typedef logic [PAT_W_DEF-1:0] pattern_t;

  localparam pattern_t PATTERN_DEF = 4'b1010;

  // Fill counter must be able to hold the value PAT_W itself.
  function automatic int cnt_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(PAT_W_DEF);

endpackage

// File: rtl/seq_det_history.sv
// Sample history shift register with a saturating fill counter; clr discards all state.
module seq_det_history
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = cnt_width(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clr,
  output logic [PAT_W-1:0] window,
  output logic             full
);

  logic [PAT_W-2:0] hist;
  logic [CNT_W-1:0] fill;

  assign window = {hist, din};
  // The current sample completes the window once PAT_W-1 earlier samples are held.
  assign full   = (fill >= CNT_W'(PAT_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= window[PAT_W-2:0];
      if (fill != CNT_W'(PAT_W))
        fill <= fill + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_model.sv
// Serial sync-word detector with a registered one-cycle match flag.
// Define SEQ_DET_NONOVERLAP_EN to restart detection after each match (no shared bits).
module seq_detector_model
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  logic [PAT_W-1:0] window;
  logic             full;
  logic             match;
  logic             clr;

  assign match = full && (window == PATTERN);

`ifdef SEQ_DET_NONOVERLAP_EN
  assign clr = match;
`else
  assign clr = 1'b0;
`endif

  seq_det_history #(
    .PAT_W (PAT_W)
  ) u_history (
    .clk    (clk),
    .rst    (resetn),
    .din    (din),
    .clr    (clr),
    .window (window),
    .full   (full)
  );

  // resetn is active-high despite its name.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn)
      dout <= 1'b0;
    else
      dout <= match;
  end

endmodule

// File: tb/tb_seq_detector_model.sv
// Directed bench for seq_detector_model: default 1010 instance plus an all-zero-pattern instance.
module tb_seq_detector_model;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic din = 1'b0;
  logic din_z = 1'b0;
  logic dout;
  logic dout_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_model dut (
    .clk    (clk),
    .resetn (resetn),
    .din    (din),
    .dout   (dout)
  );

  seq_detector_model #(
    .PAT_W   (4),
    .PATTERN (4'b0000)
  ) dut_z (
    .clk    (clk),
    .resetn (resetn),
    .din    (din_z),
    .dout   (dout_z)
  );

`ifdef SEQ_DET_NONOVERLAP_EN
  localparam logic [31:0] EXP_STREAM = 32'h0008_4408;
  localparam logic [31:0] EXP_ZERO   = 32'h0000_0888;
  localparam logic [31:0] EXP_ALT    = 32'h0000_0088;
`else
  localparam logic [31:0] EXP_STREAM = 32'h0008_5408;
  localparam logic [31:0] EXP_ZERO   = 32'h0000_0FF8;
  localparam logic [31:0] EXP_ALT    = 32'h0000_02A8;
`endif

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Entered and left at a negedge; releases reset at a negedge so the next edge takes sample 0.
  task automatic do_reset();
    resetn = 1'b1;
    #1 chk("rst_async", dout, 1'b0);
    for (int i = 0; i < 2; i++) begin
      din = ~din;
      @(posedge clk);
      #1 chk("rst_hold", dout, 1'b0);
      chk("rst_hold_z", dout_z, 1'b0);
      @(negedge clk);
    end
    resetn = 1'b0;
  endtask

  // bits: n samples, MSB first; mask bit i = expected dout right after sample i.
  task automatic run_bits(input string tag, input logic [31:0] bits, input int n,
                          input logic [31:0] mask, input bit z_en, input logic [31:0] z_mask);
    logic [31:0] b;
    logic [31:0] m;
    logic [31:0] mz;
    b  = bits;
    m  = mask;
    mz = z_mask;
    for (int i = 0; i < n; i++) begin
      din   = b[n-1-i];
      din_z = 1'b0;
      @(posedge clk);
      #1 chk($sformatf("%s[%0d]", tag, i), dout, m[i]);
      if (z_en) chk($sformatf("%s_z[%0d]", tag, i), dout_z, mz[i]);
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Main stream, also exercises the fill gate on the first three samples.
    run_bits("stream", 32'hAF55_AF00, 32, EXP_STREAM, 1'b0, 32'h0);

    // Mid-stream reset discards partial history.
    do_reset();
    run_bits("pre", 32'h5, 3, 32'h0, 1'b0, 32'h0);
    resetn = 1'b1;
    #1 chk("mid_rst_async", dout, 1'b0);
    @(posedge clk);
    #1 chk("mid_rst_edge", dout, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    run_bits("post0", 32'h0, 1, 32'h0, 1'b0, 32'h0);
    run_bits("post1010", 32'hA, 4, 32'h8, 1'b0, 32'h0);
    chk("pulse_held", dout, 1'b1);
    resetn = 1'b1;
    #1 chk("pulse_async_clr", dout, 1'b0);
    @(negedge clk);

    // All-zero pattern: leading zero history must not alias.
    do_reset();
    run_bits("zeros", 32'h0, 12, 32'h0, 1'b1, EXP_ZERO);

    // Alternating stream.
    do_reset();
    run_bits("alt", 32'h2AA, 10, EXP_ALT, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
